// File: rtl/uart_cmd_comm.sv
// uart_cmd_comm: host-side 8N1 UART front end.
// Receives bytes on RX and assembles each group of three into a 24-bit command
// (first byte in [23:16]); serializes single response bytes onto TX.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   RX / TX             serial in from host / serial out to host (idle high)
//   cmd, cmd_rdy        assembled command and its pending flag
//   clr_cmd_rdy         one-clock pulse clearing cmd_rdy
//   resp_data, send_resp  response byte and its one-clock send request
//   resp_sent           one-clock pulse when the stop bit has been sent
module uart_cmd_comm #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned FRAME_TO = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO_W  = 24;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(FRAME_TO);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  // ---------------------------------------------------------------- RX side
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bits, rx_bits_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_byte_ok, rx_byte_ok_nxt;
  logic             rx_frame_err, rx_frame_err_nxt;

  logic [1:0]       byte_cnt;
  logic [TO_W-1:0]  to_cnt;

  // RX synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bits      <= '0;
      rx_shift     <= '0;
      rx_byte_ok   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_nxt;
      rx_cnt       <= rx_cnt_nxt;
      rx_bits      <= rx_bits_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_byte_ok   <= rx_byte_ok_nxt;
      rx_frame_err <= rx_frame_err_nxt;
    end
  end

  // RX next-state: half-bit start check, then one sample per bit period
  always_comb begin
    rx_state_nxt     = rx_state;
    rx_cnt_nxt       = rx_cnt + CNT_W'(1);
    rx_bits_nxt      = rx_bits;
    rx_shift_nxt     = rx_shift;
    rx_byte_ok_nxt   = 1'b0;
    rx_frame_err_nxt = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt  = '0;
        rx_bits_nxt = '0;
        if (!rx_sync && rx_prev) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_bits_nxt  = rx_bits + 3'd1;
          if (rx_bits == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt       = '0;
          rx_state_nxt     = RX_IDLE;
          rx_byte_ok_nxt   = rx_sync;
          rx_frame_err_nxt = !rx_sync;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Command assembly, pending flag and partial-frame timeout.
  // A set in the same cycle as clr_cmd_rdy wins because it is written last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      byte_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      if (rx_byte_ok) begin
        to_cnt <= '0;
        if (!cmd_rdy) begin
          case (byte_cnt)
            2'd0:    cmd[23:16] <= rx_shift;
            2'd1:    cmd[15:8]  <= rx_shift;
            default: cmd[7:0]   <= rx_shift;
          endcase
          if (byte_cnt == 2'd2) begin
            byte_cnt <= '0;
            cmd_rdy  <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
      end else if (rx_frame_err) begin
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else if (byte_cnt == 2'd0) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LIMIT) begin
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else if (rx_state == RX_IDLE) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- TX side
  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [3:0]       tx_bits, tx_bits_nxt;
  logic [8:0]       tx_shift, tx_shift_nxt;   // data bits then stop bit
  logic             tx_line_nxt, resp_sent_nxt;

  // TX FSM state and registered line/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      tx_shift  <= '0;
      TX        <= 1'b1;
      resp_sent <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_bits   <= tx_bits_nxt;
      tx_shift  <= tx_shift_nxt;
      TX        <= tx_line_nxt;
      resp_sent <= resp_sent_nxt;
    end
  end

  // TX next-state: start bit driven on accept, then one bit per period
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_cnt_nxt    = tx_cnt + CNT_W'(1);
    tx_bits_nxt   = tx_bits;
    tx_shift_nxt  = tx_shift;
    tx_line_nxt   = TX;
    resp_sent_nxt = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt  = '0;
        tx_bits_nxt = '0;
        tx_line_nxt = 1'b1;
        if (send_resp) begin
          tx_shift_nxt = {1'b1, resp_data};
          tx_line_nxt  = 1'b0;
          tx_state_nxt = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          if (tx_bits == 4'd9) begin
            tx_state_nxt  = TX_IDLE;
            tx_line_nxt   = 1'b1;
            resp_sent_nxt = 1'b1;
          end else begin
            tx_line_nxt  = tx_shift[0];
            tx_shift_nxt = {1'b1, tx_shift[8:1]};
            tx_bits_nxt  = tx_bits + 4'd1;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_comm.sv
// Scoreboard bench for uart_cmd_comm: stimulus pushes expected commands and
// response bytes into queues; monitors pop and compare when the DUT presents them.
module tb_uart_cmd_comm;

  localparam int B  = 16;
  localparam int TO = 400;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
  logic [23:0] cmd;
  logic [7:0]  resp_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] exp_cmd[$];
  logic [7:0]  exp_tx[$];
  logic        prev_rdy;
  logic        tx_prev;

  uart_cmd_comm #(.BAUD_DIV(B), .FRAME_TO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_bit(input logic v);
    #1 RX = v;
    repeat (B) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (!stop_bit) begin
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
  endtask

  task automatic send_cmd(input logic [23:0] c);
    send_byte(c[23:16], 1'b1);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic clear_rdy();
    #1 clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    @(negedge clk);
    check("rdy_cleared", 32'(cmd_rdy), 32'd0);
  endtask

  task automatic pulse_send(input logic [7:0] d);
    #1 resp_data = d;
    send_resp = 1'b1;
    @(posedge clk);
    #1 send_resp = 1'b0;
  endtask

  task automatic wait_resp_sent(input string name);
    int k;
    k = 0;
    while (!resp_sent && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(resp_sent), 32'd1);
  endtask

  task automatic neg_wait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  // Command monitor: every rising cmd_rdy must match the next expected command
  initial begin
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_rdy && !prev_rdy) begin
        if (exp_cmd.size() == 0) begin
          n_checks++;
          $display("FAIL cmd_rdy_unexpected: cmd %h with nothing pending", cmd);
        end else begin
          check("cmd_value", 32'(cmd), 32'(exp_cmd.pop_front()));
        end
      end
      prev_rdy = cmd_rdy;
    end
  end

  // TX monitor: decode each frame mid-bit and time resp_sent from the start edge
  initial begin
    logic [7:0] got;
    logic       start_v, stop_v, tx_at_sent;
    bit         ab;
    int         rs_at;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev && !TX) begin
        ab = 1'b0;
        neg_wait(B / 2, ab);
        start_v = TX;
        for (int i = 0; i < 8; i++) begin
          neg_wait(B, ab);
          got[i] = TX;
        end
        neg_wait(B, ab);
        stop_v = TX;
        rs_at = 0;
        tx_at_sent = 1'b0;
        for (int j = 1; j <= B / 2; j++) begin
          neg_wait(1, ab);
          if (resp_sent && rs_at == 0) begin
            rs_at = j;
            tx_at_sent = TX;
          end
        end
        if (!ab) begin
          if (exp_tx.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected: byte %h with nothing pending", got);
          end else begin
            check("tx_byte", 32'(got), 32'(exp_tx.pop_front()));
            check("tx_start_bit", 32'(start_v), 32'd0);
            check("tx_stop_bit", 32'(stop_v), 32'd1);
            check("resp_sent_timing", 32'(rs_at), 32'(B / 2));
            check("tx_high_at_resp_sent", 32'(tx_at_sent), 32'd1);
          end
        end else begin
          while (!rst_n) @(negedge clk);
        end
      end
      tx_prev = TX;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RX = 1'b1; rst_n = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_resp_sent", 32'(resp_sent), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Normal command, held until cleared; bytes while pending are dropped
    exp_cmd.push_back(24'h021D81);
    send_cmd(24'h021D81);
    @(negedge clk);
    check("rdy_after_cmd1", 32'(cmd_rdy), 32'd1);
    repeat (20) @(negedge clk);
    check("rdy_held", 32'(cmd_rdy), 32'd1);
    send_cmd(24'h090000);
    @(negedge clk);
    check("cmd_unchanged_while_pending", 32'(cmd), 32'h021D81);
    check("rdy_still_high", 32'(cmd_rdy), 32'd1);
    clear_rdy();
    check("cmd_holds_after_clear", 32'(cmd), 32'h021D81);
    exp_cmd.push_back(24'h050003);
    send_cmd(24'h050003);
    @(negedge clk);
    check("rdy_after_cmd2", 32'(cmd_rdy), 32'd1);
    clear_rdy();

    // Framing error restarts the byte count
    exp_cmd.push_back(24'h000007);
    send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b0);
    send_cmd(24'h000007);
    @(negedge clk);
    check("rdy_after_frame_err", 32'(cmd_rdy), 32'd1);
    clear_rdy();

    // Timeout abandons a partial command
    exp_cmd.push_back(24'h030080);
    send_byte(8'h03, 1'b1);
    repeat (500) @(posedge clk);
    send_cmd(24'h030080);
    @(negedge clk);
    check("rdy_after_timeout_cmd", 32'(cmd_rdy), 32'd1);
    clear_rdy();

    // Short glitch is not a byte
    #1 RX = 1'b0;
    repeat (4) @(posedge clk);
    #1 RX = 1'b1;
    repeat (200) @(negedge clk);
    check("cmd_after_glitch", 32'(cmd), 32'h030080);
    check("rdy_after_glitch", 32'(cmd_rdy), 32'd0);
    exp_cmd.push_back(24'h123456);
    send_cmd(24'h123456);
    @(negedge clk);
    check("rdy_after_cmd_glitch", 32'(cmd_rdy), 32'd1);

    // TX: ignored second request, then back-to-back send on resp_sent
    @(posedge clk);
    exp_tx.push_back(8'hA5);
    pulse_send(8'hA5);
    repeat (48) @(posedge clk);
    pulse_send(8'hFF);
    @(negedge clk);
    wait_resp_sent("resp_sent_a5");
    resp_data = 8'h3C;
    send_resp = 1'b1;
    exp_tx.push_back(8'h3C);
    @(posedge clk);
    #1 send_resp = 1'b0;
    @(negedge clk);
    wait_resp_sent("resp_sent_3c");
    @(negedge clk);
    check("resp_sent_one_cycle", 32'(resp_sent), 32'd0);
    repeat (200) @(negedge clk);

    // Reset during RX and TX data bits
    @(posedge clk);
    pulse_send(8'h5A);
    fork
      send_byte(8'h6B, 1'b1);
      begin
        repeat (60) @(posedge clk);
        #3;
        check("tx_before_reset", 32'(TX), 32'd0);
        check("rdy_before_reset", 32'(cmd_rdy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("tx_async_reset", 32'(TX), 32'd1);
        check("rdy_async_reset", 32'(cmd_rdy), 32'd0);
        check("cmd_async_reset", 32'(cmd), 32'd0);
      end
    join
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("tx_after_reset", 32'(TX), 32'd1);
    check("resp_sent_after_reset", 32'(resp_sent), 32'd0);
    exp_cmd.push_back(24'hA1B2C3);
    send_cmd(24'hA1B2C3);
    @(negedge clk);
    check("rdy_after_reset_cmd", 32'(cmd_rdy), 32'd1);
    clear_rdy();

    repeat (20) @(negedge clk);
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
